// File: rtl/tennis_pkg.sv
// tennis_pkg: shared state encoding and default divide constants for the ball speed logic
package tennis_pkg;
  typedef enum logic [1:0] {IDLE, RALLY, HOLDOFF} state_t;
  localparam int DFLT_DIV_W     = 28;
  localparam int DFLT_START_DIV = 2_500_000;
  localparam int DFLT_STEP_DIV  = 200_000;
  localparam int DFLT_MIN_DIV   = 500_000;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector with synchronous reset
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk_in) q <= rst ? 1'b0 : d;
  assign rise = d & ~q;
endmodule

// File: rtl/ball_speed_ctrl.sv
// ball_speed_ctrl: shortens the clk_divider divide value per paddle hit, restores it on a point
module ball_speed_ctrl
  import tennis_pkg::*;
#(
  parameter int DIV_W          = DFLT_DIV_W,
  parameter int START_DIV      = DFLT_START_DIV,
  parameter int STEP_DIV       = DFLT_STEP_DIV,
  parameter int MIN_DIV        = DFLT_MIN_DIV,
  parameter int HOLDOFF_CYCLES = 1_000_000,
  parameter int CNT_W          = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             serve,
  input  logic             hit,
  input  logic             point_scored,
  output logic [DIV_W-1:0] divby,
  output logic             divby_changed,
  output logic [CNT_W-1:0] hit_count,
  output logic             at_max_speed
);
  localparam int TMR_W = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
  localparam logic [DIV_W-1:0] START_V = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W:0] STEP_V = (DIV_W + 1)'(STEP_DIV);
  if (STEP_DIV <= 0 || MIN_DIV > START_DIV || longint'(START_DIV) >= (longint'(1) << DIV_W)
      || HOLDOFF_CYCLES < 1) begin : g_bad_params
    $error("ball_speed_ctrl: illegal parameter combination");
  end
  state_t state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [DIV_W-1:0] div_n, lowered;
  logic [DIV_W:0] dif;
  logic [CNT_W-1:0] cnt_n;
  logic hit_rise, serve_rise;
  rise_detect u_hit (.clk_in(clk_in), .rst(rst), .d(hit), .rise(hit_rise));
  rise_detect u_serve (.clk_in(clk_in), .rst(rst), .d(serve), .rise(serve_rise));
  // one extra bit so a step larger than the remaining headroom shows up as a borrow
  assign dif = {1'b0, divby} - STEP_V;
  assign lowered = (dif[DIV_W] || dif < {1'b0, MIN_V}) ? MIN_V : dif[DIV_W-1:0];
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    div_n = divby;
    cnt_n = hit_count;
    if (state == IDLE) begin
      state_n = serve_rise ? RALLY : IDLE;
    end else if (point_scored) begin
      state_n = IDLE;
      tmr_n = '0;
      div_n = START_V;
      cnt_n = '0;
    end else if (state == RALLY) begin
      if (hit_rise) begin
        state_n = HOLDOFF;
        tmr_n = TMR_LOAD;
        div_n = lowered;
        cnt_n = &hit_count ? hit_count : hit_count + 1'b1;
      end
    end else begin
      state_n = tmr == '0 ? RALLY : HOLDOFF;
      tmr_n = tmr == '0 ? tmr : tmr - 1'b1;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      tmr <= '0;
      divby <= START_V;
      divby_changed <= 1'b0;
      hit_count <= '0;
      at_max_speed <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      divby <= div_n;
      divby_changed <= div_n != divby;
      hit_count <= cnt_n;
      at_max_speed <= div_n == MIN_V;
    end
  end
endmodule

// File: tb/tb_ball_speed_ctrl.sv
// tb_ball_speed_ctrl: directed test-plan scenarios plus random play against a rule-level model
module tb_ball_speed_ctrl;
  localparam int START = 100, STEP = 30, MIN = 20, HOLD = 4, CMAX = 255;
  logic clk_in = 1'b0;
  logic rst = 1'b1, serve = 1'b0, hit = 1'b0, point_scored = 1'b0;
  logic [27:0] divby;
  logic divby_changed, at_max_speed;
  logic [7:0] hit_count;
  int tests = 0, fails = 0;
  ball_speed_ctrl #(.DIV_W(28), .START_DIV(START), .STEP_DIV(STEP), .MIN_DIV(MIN),
                    .HOLDOFF_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk_in(clk_in), .rst(rst), .serve(serve), .hit(hit), .point_scored(point_scored),
    .divby(divby), .divby_changed(divby_changed), .hit_count(hit_count),
    .at_max_speed(at_max_speed)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // rule-level model: a hit rise counts only in a rally and only if more than HOLD cycles
  // have passed since the previous counted hit of that rally
  int m_div = START, m_cnt = 0, m_chg = 0, m_max = 0, m_cyc = 0, m_last = -1000;
  bit m_rally = 0, m_hq = 0, m_sq = 0;
  initial forever begin
    @(posedge clk_in);
    #1;
    m_cyc++;
    if (rst) begin
      m_div = START; m_cnt = 0; m_chg = 0; m_max = 0; m_rally = 0; m_hq = 0; m_sq = 0;
    end else begin
      automatic int old = m_div;
      automatic bit hr = hit && !m_hq, sr = serve && !m_sq;
      if (!m_rally) begin
        if (sr) begin m_rally = 1; m_last = -1000; end
      end else if (point_scored) begin
        m_rally = 0; m_div = START; m_cnt = 0;
      end else if (hr && m_cyc - m_last > HOLD) begin
        m_div = m_div - STEP < MIN ? MIN : m_div - STEP;
        m_cnt = m_cnt < CMAX ? m_cnt + 1 : CMAX;
        m_last = m_cyc;
      end
      m_chg = int'(m_div != old);
      m_max = int'(m_div == MIN);
      m_hq = hit; m_sq = serve;
    end
    chk("divby", divby, m_div);
    chk("hit_count", hit_count, m_cnt);
    chk("divby_changed", divby_changed, m_chg);
    chk("at_max_speed", at_max_speed, m_max);
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic pulse_serve();
    serve = 1; step(1); serve = 0; step(1);
  endtask
  task automatic do_hit();
    hit = 1; step(1); hit = 0; step(5);
  endtask
  initial begin
    int pulses;
    int exp_div[4] = '{70, 40, 20, 20};
    step(2);
    rst = 0; step(1);
    chk("t1 divby", divby, 100); chk("t1 cnt", hit_count, 0);
    chk("t1 max", at_max_speed, 0); chk("t1 chg", divby_changed, 0);
    hit = 1; step(1); hit = 0; step(1);
    chk("t2 idle hit", divby, 100);
    pulse_serve();
    hit = 1; pulses = 0;
    repeat (10) begin step(1); pulses += int'(divby_changed); end
    hit = 0; step(1);
    chk("t2 divby", divby, 70); chk("t2 cnt", hit_count, 1); chk("t2 pulses", pulses, 1);
    point_scored = 1; step(1); point_scored = 0;
    pulse_serve();
    hit = 1; step(1); hit = 0; step(1); hit = 1; step(1); hit = 0; step(6);
    chk("t3 divby", divby, 70); chk("t3 cnt", hit_count, 1);
    point_scored = 1; step(1); point_scored = 0;
    pulse_serve();
    for (int i = 0; i < 4; i++) begin
      hit = 1; step(1);
      chk("t4 divby", divby, exp_div[i]);
      chk("t4 chg", divby_changed, i < 3 ? 1 : 0);
      chk("t4 max", at_max_speed, i >= 2 ? 1 : 0);
      hit = 0; step(5);
    end
    chk("t4 cnt", hit_count, 4);
    point_scored = 1; hit = 1; step(1);
    chk("t5 divby", divby, 100); chk("t5 cnt", hit_count, 0); chk("t5 chg", divby_changed, 1);
    point_scored = 0; hit = 0; step(1);
    chk("t5 chg once", divby_changed, 0);
    hit = 1; step(1); hit = 0; step(1);
    chk("t5 idle", divby, 100);
    pulse_serve();
    do_hit(); hit = 1; step(2); hit = 0;
    chk("t6 pre", divby, 40);
    rst = 1; step(1); rst = 0;
    chk("t6 divby", divby, 100); chk("t6 cnt", hit_count, 0);
    chk("t6 chg", divby_changed, 0); chk("t6 max", at_max_speed, 0);
    step(1); hit = 1; step(1); hit = 0; step(2);
    chk("t6 no serve", divby, 100); chk("t6 no serve cnt", hit_count, 0);
    pulse_serve();
    repeat (260) do_hit();
    chk("sat cnt", hit_count, 255); chk("sat divby", divby, 20);
    point_scored = 1; step(1); point_scored = 0;
    repeat (4000) begin
      rst = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, 24) == 0) serve = ~serve;
      hit = $urandom_range(0, 3) == 0;
      point_scored = $urandom_range(0, 79) == 0;
      step(1);
    end
    rst = 0; hit = 0; serve = 0; point_scored = 0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
